chal_resp_auth: RTL and testbench

Parametrised challenge-response authentication engine for the ChaCha20 UART control path. Periodically snapshots a random challenge and has an external cipher encrypt it. It then emits "CHAL:<hex>\n" on a byte stream and verifies "RESP:<hex>\n" on the incoming stream by streaming nibble compare, with no response buffer. It sits between uart_rx/uart_tx and chacha20_compact, and forwards non-response bytes to downstream command logic while authenticated.

---
 rtl/chal_resp_auth_if.sv | 42 ++++
 rtl/chal_resp_auth.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_chal_resp_auth.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chal_resp_auth_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chal_resp_auth_if                                                          |
// | Cipher, byte-stream and status bundle of the challenge-response engine.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface chal_resp_auth_if #(
    parameter int CHAL_BYTES = 16,
    parameter int MAX_FAILS  = 3
);
    localparam int c_chal_w = 8 * CHAL_BYTES;
    localparam int c_fail_w = $clog2(MAX_FAILS + 1);

    logic [c_chal_w-1:0] rand_in;
    logic                cipher_start;
    logic [c_chal_w-1:0] cipher_pt;
    logic [c_chal_w-1:0] cipher_ct;
    logic                cipher_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          cmd_data;
    logic                cmd_valid;
    logic                authenticated;
    logic                locked;
    logic [c_fail_w-1:0] fail_count;

    modport master (
        input  rand_in, cipher_ct, cipher_valid, tx_ready, rx_data, rx_valid,
        output cipher_start, cipher_pt, tx_data, tx_valid, cmd_data, cmd_valid,
        output authenticated, locked, fail_count
    );

    modport slave (
        output rand_in, cipher_ct, cipher_valid, tx_ready, rx_data, rx_valid,
        input  cipher_start, cipher_pt, tx_data, tx_valid, cmd_data, cmd_valid,
        input  authenticated, locked, fail_count
    );
endinterface
`default_nettype wire

// File: rtl/chal_resp_auth.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chal_resp_auth                                                             |
// | Periodic CHAL:<hex> challenge, streaming RESP:<hex> check, command gate.   |
// | Optional feature macro: AUTH_LOCKOUT_EN (lockout after MAX_FAILS).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chal_resp_auth #(
    parameter int CHAL_BYTES     = 16,
    parameter int PERIOD_CYCLES  = 60000000,
    parameter int TIMEOUT_CYCLES = 60000000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 240000000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    chal_resp_auth_if.master bus
);
    localparam int c_chal_w   = 8 * CHAL_BYTES;
    localparam int c_hex_n    = 2 * CHAL_BYTES;
    localparam int c_last     = 5 + c_hex_n;
    localparam int c_idx_w    = $clog2(c_last + 1);
    localparam int c_fail_w   = $clog2(MAX_FAILS + 1);
    localparam int c_pt_max   = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
    localparam int c_tmr_max  = (c_pt_max > LOCKOUT_CYCLES) ? c_pt_max : LOCKOUT_CYCLES;
    localparam int c_tmr_w    = $clog2(c_tmr_max + 1);

    localparam logic [c_idx_w-1:0]  c_idx_last   = c_idx_w'(c_last);
    localparam logic [c_idx_w-1:0]  c_idx_hex    = c_idx_w'(5);
    localparam logic [c_fail_w-1:0] c_fail_max   = c_fail_w'(MAX_FAILS);
    localparam logic [c_tmr_w-1:0]  c_per_last   = c_tmr_w'(PERIOD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]  c_tmo_last   = c_tmr_w'(TIMEOUT_CYCLES - 1);
`ifdef AUTH_LOCKOUT_EN
    localparam logic [c_tmr_w-1:0]  c_lock_last  = c_tmr_w'(LOCKOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CIPHER  = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT    = 3'd3,
        S_VERIFY  = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_tmr_w-1:0]  timer_q, timer_d;
    logic [c_chal_w-1:0] pt_q, pt_d;
    logic [c_chal_w-1:0] exp_q, exp_d;
    logic [c_idx_w-1:0]  idx_q, idx_d;
    logic                err_q, err_d;
    logic                auth_q, auth_d;
    logic [c_fail_w-1:0] fail_q, fail_d;
    logic                start_q, start_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [7:0]          cmd_data_q, cmd_data_d;
`ifdef AUTH_LOCKOUT_EN
    logic                locked_q, locked_d;
`endif
    logic                w_consume;
    logic                w_final;
    logic                w_fail;
    logic [4:0]          w_dec;
    logic [7:0]          w_tx_data;
    logic [c_fail_w-1:0] w_fail_inc;

    // Nibble k of v counted from the most significant end.
    function automatic logic [3:0] nib_at(input logic [c_chal_w-1:0] v, input logic [c_idx_w-1:0] k);
        logic [3:0] r;
        r = '0;
        for (int n = 0; n < c_hex_n; n++) begin
            if (k == c_idx_w'(n)) r = v[c_chal_w-1-4*n -: 4];
        end
        return r;
    endfunction

    // Returns {valid, nibble}; accepts both letter cases.
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] tx_hdr(input logic [c_idx_w-1:0] k);
        case (int'(k))
            0:       return 8'h43;
            1:       return 8'h48;
            2:       return 8'h41;
            3:       return 8'h4C;
            default: return 8'h3A;
        endcase
    endfunction

    function automatic logic [7:0] rx_hdr(input logic [c_idx_w-1:0] k);
        case (int'(k))
            1:       return 8'h45;
            2:       return 8'h53;
            3:       return 8'h50;
            default: return 8'h3A;
        endcase
    endfunction

    assign w_fail_inc = (fail_q == c_fail_max) ? fail_q : fail_q + c_fail_w'(1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pt_d        = pt_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        err_d       = err_q;
        auth_d      = auth_q;
        fail_d      = fail_q;
        start_d     = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
`ifdef AUTH_LOCKOUT_EN
        locked_d    = locked_q;
`endif
        w_consume   = 1'b0;
        w_final     = 1'b0;
        w_fail      = 1'b0;
        w_dec       = hex_dec(bus.rx_data);

        case (state_q)
            S_IDLE: begin
                if (timer_q == c_per_last) begin
                    pt_d    = bus.rand_in;
                    timer_d = '0;
                    start_d = 1'b1;
                    state_d = S_CIPHER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CIPHER: begin
                if (bus.cipher_valid) begin
                    exp_d   = bus.cipher_ct;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    if (idx_q == c_idx_last) begin
                        timer_d = '0;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // Until an 'R' arrives the parser is idle and bytes pass through.
                if (bus.rx_valid && ((idx_q != '0) || (bus.rx_data == 8'h52))) begin
                    w_consume = 1'b1;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == c_idx_last) begin
                        w_final = 1'b1;
                        state_d = S_VERIFY;
                        if (bus.rx_data != 8'h0A) err_d = 1'b1;
                    end else if (idx_q >= c_idx_hex) begin
                        if (!w_dec[4] || (w_dec[3:0] != nib_at(exp_q, idx_q - c_idx_hex)))
                            err_d = 1'b1;
                    end else if (idx_q != '0) begin
                        if (bus.rx_data != rx_hdr(idx_q)) err_d = 1'b1;
                    end
                end
                if (!w_final && (timer_q == c_tmo_last)) w_fail = 1'b1;
            end
            S_VERIFY: begin
                if (err_q) begin
                    w_fail = 1'b1;
                end else begin
                    auth_d  = 1'b1;
                    fail_d  = '0;
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
`ifdef AUTH_LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer_q == c_lock_last) begin
                    locked_d = 1'b0;
                    fail_d   = '0;
                    timer_d  = '0;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase

        if (w_fail) begin
            auth_d  = 1'b0;
            fail_d  = w_fail_inc;
            timer_d = '0;
            state_d = S_IDLE;
`ifdef AUTH_LOCKOUT_EN
            if (w_fail_inc == c_fail_max) begin
                state_d  = S_LOCKOUT;
                locked_d = 1'b1;
            end
`endif
        end

        if (bus.rx_valid && auth_q && !w_consume) begin
            cmd_valid_d = 1'b1;
            cmd_data_d  = bus.rx_data;
        end
    end

    always_comb begin
        w_tx_data = 8'h00;
        if (state_q == S_SEND) begin
            if (idx_q < c_idx_hex)
                w_tx_data = tx_hdr(idx_q);
            else if (idx_q == c_idx_last)
                w_tx_data = 8'h0A;
            else
                w_tx_data = hex_enc(nib_at(pt_q, idx_q - c_idx_hex));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            pt_q        <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            auth_q      <= 1'b0;
            fail_q      <= '0;
            start_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= 8'h00;
`ifdef AUTH_LOCKOUT_EN
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pt_q        <= pt_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            auth_q      <= auth_d;
            fail_q      <= fail_d;
            start_q     <= start_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
`ifdef AUTH_LOCKOUT_EN
            locked_q    <= locked_d;
`endif
        end
    end

    assign bus.cipher_start  = start_q;
    assign bus.cipher_pt     = pt_q;
    assign bus.tx_valid      = (state_q == S_SEND);
    assign bus.tx_data       = w_tx_data;
    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.cmd_data      = cmd_data_q;
    assign bus.authenticated = auth_q;
    assign bus.fail_count    = fail_q;
`ifdef AUTH_LOCKOUT_EN
    assign bus.locked        = locked_q;
`else
    assign bus.locked        = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_chal_resp_auth.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chal_resp_auth                                                          |
// | Directed bench: challenge framing, responses, timeout, reset, lockout.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_chal_resp_auth;
    localparam int CB   = 2;
    localparam int PER  = 100;
    localparam int TMO  = 200;
    localparam int MF   = 3;
    localparam int LOCK = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chal_resp_auth_if #(.CHAL_BYTES(CB), .MAX_FAILS(MF)) bus ();

    chal_resp_auth #(
        .CHAL_BYTES    (CB),
        .PERIOD_CYCLES (PER),
        .TIMEOUT_CYCLES(TMO),
        .MAX_FAILS     (MF),
        .LOCKOUT_CYCLES(LOCK)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors (sampled mid-cycle on the falling edge)
    int          cyc = 0;
    logic [7:0]  txq[$];
    int          tx_acc_cyc = 0;
    int          start_cnt  = 0;
    int          start_cyc  = 0;
    int          cmd_cnt    = 0;
    logic [7:0]  cmd_last   = 8'h00;
    int          stab_err   = 0;
    logic        pend       = 1'b0;
    logic [7:0]  pend_data  = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && bus.tx_valid && (bus.tx_data != pend_data)) stab_err++;
            if (bus.tx_valid && bus.tx_ready) begin
                txq.push_back(bus.tx_data);
                tx_acc_cyc = cyc + 1;
            end
            pend      = bus.tx_valid && !bus.tx_ready;
            pend_data = bus.tx_data;
            if (bus.cipher_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (bus.cmd_valid) begin
                cmd_cnt++;
                cmd_last = bus.cmd_data;
            end
        end
    end

    // Sink readiness: always ready, or one cycle in three
    int rdy_mode = 0;
    initial begin
        int ph;
        ph = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            bus.tx_ready = (rdy_mode == 0) || (ph % 3 == 0);
        end
    end

    // Cipher model: result valid five cycles after the start pulse
    initial begin
        int cdly;
        cdly = 0;
        bus.cipher_valid = 1'b0;
        bus.cipher_ct    = 16'h1A2B;
        forever begin
            @(posedge clk);
            #2;
            bus.cipher_valid = 1'b0;
            if (cdly > 0) begin
                cdly--;
                if (cdly == 0) bus.cipher_valid = 1'b1;
            end
            if (bus.cipher_start) cdly = 5;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] f_beef [10] = '{8'h43, 8'h48, 8'h41, 8'h4C, 8'h3A, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    logic [7:0] f_c0de [10] = '{8'h43, 8'h48, 8'h41, 8'h4C, 8'h3A, 8'h43, 8'h30, 8'h44, 8'h45, 8'h0A};

    task automatic wait_tx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, txq.size(), n);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp [10]);
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    endtask

    task automatic send_rx(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.rx_data  = s[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        int rel, c0, s0, t0, k, n;
        bus.rand_in  = 16'hBEEF;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_cipher_start", bus.cipher_start, 0);
        check("rst_cipher_pt", bus.cipher_pt, 0);
        check("rst_auth", bus.authenticated, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_fail", bus.fail_count, 0);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        rst = 1'b0;
        rel = cyc;

        // First challenge
        wait_tx("t1_frame_len", 10, 400);
        check_frame("t1", f_beef);
        check("t1_start_lat", start_cyc - rel, PER);
        check("t1_start_cnt", start_cnt, 1);
        check("t1_pt", bus.cipher_pt, 16'hBEEF);

        // Correct lowercase response, then a command byte
        send_rx("RESP:1a2b\n");
        @(negedge clk);
        check("t2_auth", bus.authenticated, 1);
        check("t2_fail", bus.fail_count, 0);
        c0 = cmd_cnt;
        send_rx("Y");
        @(negedge clk);
        check("t2_cmd_cnt", cmd_cnt - c0, 1);
        check("t2_cmd_data", cmd_last, 8'h59);

        // Wrong digit while authenticated
        bus.rand_in = 16'h0123;
        txq.delete();
        wait_tx("t3_frame_len", 10, 400);
        check("t3_hex3", (txq.size() > 8) ? 32'(txq[8]) : 32'hFFFF_FFFF, 8'h33);
        c0 = cmd_cnt;
        send_rx("RESP:1A2C\n");
        @(negedge clk);
        check("t3_auth", bus.authenticated, 0);
        check("t3_fail", bus.fail_count, 1);
        check("t3_no_cmd", cmd_cnt - c0, 0);
        send_rx("Q");
        @(negedge clk);
        check("t3_unauth_no_cmd", cmd_cnt - c0, 0);

        // Garbage before 'R' does not spoil a good response
        txq.delete();
        wait_tx("t4a_frame_len", 10, 400);
        c0 = cmd_cnt;
        send_rx("x");
        send_rx("RESP:1A2B\n");
        @(negedge clk);
        check("t4a_auth", bus.authenticated, 1);
        check("t4a_fail", bus.fail_count, 0);
        check("t4a_no_cmd", cmd_cnt - c0, 0);

        // Timeout; idle-parser byte forwarded while still authenticated
        txq.delete();
        wait_tx("t4b_frame_len", 10, 400);
        c0 = cmd_cnt;
        send_rx("x");
        @(negedge clk);
        check("t4b_fwd_cnt", cmd_cnt - c0, 1);
        check("t4b_fwd_data", cmd_last, 8'h78);
        k = 0;
        while (bus.fail_count == 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t4b_tmo_lat", cyc - tx_acc_cyc, TMO);
        check("t4b_fail", bus.fail_count, 1);
        check("t4b_auth", bus.authenticated, 0);

        // Throttled sink: stable data, each byte once
        rdy_mode = 1;
        bus.rand_in = 16'hC0DE;
        stab_err = 0;
        txq.delete();
        wait_tx("t5_frame_len", 10, 800);
        check_frame("t5", f_c0de);
        check("t5_stable", stab_err, 0);
        send_rx("RESP:0000\n");
        @(negedge clk);
        check("t5_fail", bus.fail_count, 2);
        check("t5_once", txq.size(), 10);

        // Reset in the middle of a frame
        txq.delete();
        wait_tx("t5r_partial", 3, 800);
        rst = 1'b1;
        @(negedge clk);
        check("t5r_tx_valid", bus.tx_valid, 0);
        check("t5r_fail", bus.fail_count, 0);
        rst = 1'b0;
        rel = cyc;
        rdy_mode = 0;
        s0 = start_cnt;
        k = 0;
        while (start_cnt == s0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t5r_start_lat", start_cyc - rel, PER);

        // Consecutive failures
        for (int i = 0; i < MF; i++) begin
            txq.delete();
            wait_tx($sformatf("t6_frame_len%0d", i), 10, 400);
            send_rx("RESP:FFFF\n");
            if (i < MF - 1) begin
                @(negedge clk);
                check($sformatf("t6_fail%0d", i), bus.fail_count, i + 1);
            end
        end
`ifdef AUTH_LOCKOUT_EN
        t0 = txq.size();
        s0 = start_cnt;
        n  = 0;
        k  = 0;
        @(negedge clk);
        check("t6_lock_fail", bus.fail_count, MF);
        check("t6_lock_auth", bus.authenticated, 0);
        while (bus.locked && k < 800) begin
            n++;
            @(negedge clk);
            k++;
        end
        check("t6_lock_len", n, LOCK);
        check("t6_unlock_fail", bus.fail_count, 0);
        check("t6_lock_no_tx", txq.size() - t0, 0);
        check("t6_lock_no_start", start_cnt - s0, 0);
        txq.delete();
        wait_tx("t6_after_lock", 10, 400);
`else
        @(negedge clk);
        check("t6_fail_max", bus.fail_count, MF);
        check("t6_locked", bus.locked, 0);
        txq.delete();
        wait_tx("t6_frame_sat", 10, 400);
        send_rx("RESP:FFFF\n");
        @(negedge clk);
        check("t6_fail_sat", bus.fail_count, MF);
        check("t6_auth", bus.authenticated, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
